serial_subtractor_ctrl: RTL and testbench
=========================================

# serial_subtractor_ctrl

Bit-serial WIDTH-bit subtractor controller. It sequences a single one-bit subtract cell (half-subtractor pair plus borrow flip-flop) across the operand bits, one bit per clock, and computes a − b. It sits between a requester with a start/done handshake and the one-bit subtract datapath, trading latency for area in multi-bit subtraction.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥ 2)

Ports:
- clk  input  1  rising-edge clock; one clock domain
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  registered result a − b (mod 2^WIDTH)
- borrow  output  1  registered borrow-out (1 when a < b unsigned)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load shift registers sa←a, sb←b; clear borrow flop br and the bit counter cnt; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, one bit per cycle:
  - d = sa[0] ^ sb[0] ^ br.
  - br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - sa and sb shift right by 1; d shifts into the MSB of the result shift register sr.
  - cnt increments.
- SHIFT → DONE on the cycle that processes bit WIDTH−1, i.e. cnt == WIDTH−1. On that same edge: diff ← final sr (including the last d), borrow ← final br.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE. start is ignored in DONE.
- start is ignored in SHIFT. Operands on a/b are only sampled at acceptance; changes to a/b mid-operation have no effect.
- diff and borrow change only at the SHIFT→DONE edge. They hold until the next completed operation.
- Unsigned arithmetic. diff wraps modulo 2^WIDTH. The cnt width is $clog2(WIDTH).
- Reset, asynchronous and at any time including mid-SHIFT:
  - state=IDLE, busy=0, done=0, diff=0, borrow=0.
  - sa, sb, sr, br, cnt all cleared.
  - An aborted operation produces no done.

## Timing
- Edge 0: start accepted in IDLE. busy=1 from edge 0 through edge WIDTH.
- Edges 1..WIDTH: process bits 0..WIDTH−1.
- After edge WIDTH: diff/borrow updated, done=1, busy=0.
- After edge WIDTH+1: back in IDLE with done=0. A start held high here is accepted at edge WIDTH+2.
- Latency from the start edge to done high: WIDTH cycles. Throughput: one operation per WIDTH+2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUB_SATURATE_EN
  - Defined: at SHIFT→DONE, if the final br=1 then diff ← 0 (clamp at zero) while borrow ← 1 still reports the underflow.
  - Undefined: diff is the raw modulo-2^WIDTH difference.
  - Timing and handshake are identical in both builds.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse → busy for 8 cycles, done pulse 8 cycles after acceptance, diff=0x1E, borrow=0.
- a=0x00, b=0x01 → borrow=1 and diff=0xFF. With SERIAL_SUB_SATURATE_EN defined: diff=0x00, borrow=1.
- a=0xFF, b=0xFF, then a=0x80, b=0x7F → diff=0x00, borrow=0; then diff=0x01, borrow=0. diff must hold 0x00 until the second done.
- Pulse start again and change a/b during SHIFT → no restart. Result uses the originally captured operands, and exactly one done is produced.
- Assert rst for 1 cycle mid-SHIFT (after 3 bits) → busy, done, diff, borrow all 0 immediately. No done follows. A new start then completes correctly.
- Hold start=1 continuously with a=0x10, b=0x01 → done pulses every 10 cycles, each with diff=0x0F, borrow=0.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// -----------------------------------------------------------------------------
// serial_subtractor_ctrl
//
// Bit-serial WIDTH-bit subtractor. A single one-bit subtract cell (two half
// subtractors plus a borrow flip-flop) is stepped across the operands LSB
// first, one bit per clock, producing diff = a - b (mod 2^WIDTH) and the
// unsigned borrow-out. A start/done handshake frames each operation.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request, sampled only while idle
//   a       in   WIDTH  minuend, captured when start is accepted
//   b       in   WIDTH  subtrahend, captured when start is accepted
//   busy    out  1      high while bits are being processed
//   done    out  1      one-cycle pulse, diff/borrow just updated
//   diff    out  WIDTH  registered result a - b
//   borrow  out  1      registered borrow-out (a < b unsigned)
//
// Build option:
//   SERIAL_SUB_SATURATE_EN  when defined, an underflowing result is clamped
//                           to zero on diff; borrow still reports it.
//
// Timing: accept at edge 0, bits 0..WIDTH-1 at edges 1..WIDTH, done high
// after edge WIDTH, idle again after edge WIDTH+1.
// -----------------------------------------------------------------------------
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_sa;      // minuend shift register
    logic [WIDTH-1:0] r_sb;      // subtrahend shift register
    logic [WIDTH-1:0] r_sr;      // result shift register, filled from the MSB
    logic             r_br;      // running borrow between bit positions
    logic [CNT_W-1:0] r_cnt;     // index of the bit processed this cycle
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t           w_next_state;
    logic             w_load;    // accept operands and clear the cell
    logic             w_step;    // process one bit
    logic             w_finish;  // last bit: publish the result
    logic             w_hs_x;    // first half-subtractor difference
    logic             w_d;       // difference bit of the full cell
    logic             w_br_next;
    logic [WIDTH-1:0] w_sr_next;
    logic [WIDTH-1:0] w_diff_next;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // flops sample the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    // NOTE: defaults are assigned first so every path drives every signal;
    // a missing assignment would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end

            SHIFT: begin
                // start is deliberately ignored here: no restart mid-operation
                w_step = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_finish     = 1'b1;
                    w_next_state = DONE;
                end
            end

            DONE: begin
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-bit subtract cell: a - b - borrow_in on the current LSBs
    // ------------------------------------------------------------------
    always_comb begin
        w_hs_x    = r_sa[0] ^ r_sb[0];
        w_d       = w_hs_x ^ r_br;
        // Borrow out when the minuend bit is 0 against a 1, or the bits are
        // equal and a borrow is already pending.
        w_br_next = (~r_sa[0] & r_sb[0]) | (~w_hs_x & r_br);
        w_sr_next = {w_d, r_sr[WIDTH-1:1]};
    end

    // Result presented at the SHIFT->DONE edge. After WIDTH shifts bit 0 has
    // travelled from the MSB down to position 0, so w_sr_next is aligned.
`ifdef SERIAL_SUB_SATURATE_EN
    always_comb begin
        w_diff_next = w_br_next ? '0 : w_sr_next;
    end
`else
    always_comb begin
        w_diff_next = w_sr_next;
    end
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_sr  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sr  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_sr  <= w_sr_next;
            r_br  <= w_br_next;
            // Wraps past LAST_BIT on the final step; reloaded on next start.
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output registers: result holds until the next completed operation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_finish) begin
            r_diff   <= w_diff_next;
            r_borrow <= w_br_next;
        end
    end

    // busy/done are registered from the next state so they line up with
    // r_state without a decode path after the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == SHIFT);
            r_done <= (w_next_state == DONE);
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_ctrl
//
// Directed bench for serial_subtractor_ctrl (WIDTH=8). Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_hold = '0;  // diff value the DUT should be holding

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One full operation. e_diff is the raw modulo difference; the clamp is
    // applied here for the saturating build. With disturb set, a/b are
    // scrambled and start is pulsed while bits are being processed.
    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic [WIDTH-1:0] e_diff, input logic e_borrow,
                          input bit disturb);
        int               k;
        logic [WIDTH-1:0] e_d;
        e_d = e_diff;
`ifdef SERIAL_SUB_SATURATE_EN
        if (e_borrow) e_d = '0;
`endif
        @(negedge clk);
        a     = xa;
        b     = xb;
        start = 1'b1;
        @(negedge clk);              // after acceptance edge
        start = 1'b0;
        check("busy_accept", busy, 1);
        check("done_accept", done, 0);
        @(negedge clk);
        k = 1;
        while (!done && k <= WIDTH + 4) begin
            check("busy_shift", busy, 1);
            check("diff_hold", diff, exp_hold);
            if (disturb) begin
                a     = a ^ 8'hA5;
                b     = b + 8'h13;
                start = (k == 2);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("latency", k, WIDTH);
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("diff", diff, e_d);
        check("borrow", borrow, e_borrow);
        exp_hold = e_d;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_idle", busy, 0);
        check("diff_after", diff, e_d);
    endtask

    initial begin
        int nd;
        int last;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        rst = 1'b0;

        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'hC3, 8'h41, 8'h82, 1'b0, 1'b1);

        // Abort after three bits have been processed.
        @(negedge clk);
        a     = 8'h5A;
        b     = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        exp_hold = '0;
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_idle", busy, 0);

        run_op(8'h33, 8'h44, 8'hEF, 1'b1, 1'b0);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        nd    = 0;
        last  = -1;
        for (int c = 0; c < 60 && nd < 3; c++) begin
            @(negedge clk);
            if (done) begin
                check("cont_diff", diff, 8'h0F);
                check("cont_borrow", borrow, 0);
                if (last >= 0) check("cont_period", c - last, WIDTH + 2);
                last = c;
                nd++;
            end
        end
        start = 1'b0;
        check("cont_count", nd, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
